// File: rtl/statemachine_sequencer.sv
// Programmable step sequencer: clears the target statemachine, drives w1/w2 from a DEPTH x 4 program, checks z1/z2 a cycle later.
// Optional macro SMSEQ_STOP_ON_ERR_EN ends the run at the first mismatch.
module statemachine_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [3:0]    prog_data,
   output logic          sm_w1,
   output logic          sm_w2,
   output logic          sm_reset,
   input  logic          sm_z1,
   input  logic          sm_z2,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] first_err_step
);

   typedef enum logic [2:0] {IDLE, CLEAR, DRIVE, FLUSH, DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] idx, idx_nxt;
   logic [AW:0]   len_q;
   logic [3:0]    prog [DEPTH];

   logic          chk;
   logic [AW-1:0] chk_step;
   logic          mism;
   logic          last_step;
   logic [AW:0]   err_nxt;
   logic [AW-1:0] first_nxt;

   // Program store survives reset on purpose so a rerun needs no reload.
   always_ff @(posedge clk) begin
      if (prog_we && !busy)
         prog[prog_addr] <= prog_data;
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      chk       = 1'b0;
      chk_step  = idx;
      sm_w1     = 1'b0;
      sm_w2     = 1'b0;
      last_step = ({1'b0, idx} == len_q - (AW+1)'(1));
      case (state)
         IDLE: begin
            if (start)
               state_nxt = (len == '0) ? DONE : CLEAR;
         end
         CLEAR: begin
            idx_nxt   = '0;
            state_nxt = DRIVE;
         end
         DRIVE: begin
            {sm_w1, sm_w2} = prog[idx][3:2];
            chk            = (idx != '0);
            chk_step       = idx - AW'(1);
            // idx stays on the last step so FLUSH can check prog[len-1] directly
            if (last_step)
               state_nxt = FLUSH;
            else
               idx_nxt = idx + AW'(1);
         end
         FLUSH: begin
            chk       = 1'b1;
            chk_step  = idx;
            state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      mism      = chk && ({sm_z1, sm_z2} != prog[chk_step][1:0]);
      err_nxt   = err_count;
      first_nxt = first_err_step;
      if (mism) begin
         err_nxt = err_count + (AW+1)'(1);
         if (err_count == '0)
            first_nxt = chk_step;
      end
`ifdef SMSEQ_STOP_ON_ERR_EN
      if (mism)
         state_nxt = DONE;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         idx            <= '0;
         len_q          <= '0;
         err_count      <= '0;
         first_err_step <= '0;
         pass           <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == IDLE && start) begin
            len_q          <= len;
            err_count      <= '0;
            first_err_step <= '0;
            pass           <= (len == '0);
         end else begin
            err_count      <= err_nxt;
            first_err_step <= first_nxt;
            if (state_nxt == DONE)
               pass <= (err_nxt == '0);
         end
      end
   end

   assign sm_reset = reset & (state != CLEAR);
   assign busy     = (state == CLEAR) || (state == DRIVE) || (state == FLUSH);
   assign done     = (state == DONE);

endmodule
